// File: rtl/io_in_pad_sync.sv
// io_in_pad_sync: WIDTH-channel asynchronous input pad conditioner.
// Each channel passes through a 2-flop synchroniser, then a per-channel
// stability counter that accepts a new level only after DEBOUNCE
// consecutive synchronised cycles that differ from the current level.
// Optional edge pulses (rise/fall) are built when IO_IN_PAD_SYNC_EDGE_EN
// is defined; without it the ports and their flops are absent.
module io_in_pad_sync #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEBOUNCE = 4,
    parameter logic        INIT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] top_pin,
    output logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] stable
`ifdef IO_IN_PAD_SYNC_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int unsigned      CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] INIT_V   = {WIDTH{INIT}};

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] pin_q;
    logic [WIDTH-1:0] pin_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Per-channel stability counter: accept s2 once it has differed from pin long enough
    always_comb begin
        pin_d = pin_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != pin_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    pin_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Synchroniser, counters and accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= INIT_V;
            s2_q  <= INIT_V;
            pin_q <= INIT_V;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= top_pin;
            s2_q  <= s1_q;
            pin_q <= pin_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pin    = pin_q;
    // Idle indication straight from registers; no pad path reaches it
    assign stable = ~(s2_q ^ pin_q);

`ifdef IO_IN_PAD_SYNC_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // Edge pulses for the cycle following an accepted level change
    always_comb begin
        rise_d = pin_d & ~pin_q;
        fall_d = ~pin_d & pin_q;
    end

    // Edge pulse registers; reset never generates a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule
